// File: rtl/set_bit_iter.sv
// Sequential set-bit iterator: takes a mask over valid/ready and emits the index of
// every set bit, one per output handshake, LSB-first (MODE=0) or MSB-first (MODE=1).
module set_bit_iter #(
    parameter int       WIDTH     = 8,
    parameter logic     MODE      = 1'b0,
    parameter int       CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_mask_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CNT_WIDTH-1:0] out_idx_o,
    output logic                 out_last_o
);

    logic [WIDTH-1:0]     r_mask;
    logic [CNT_WIDTH-1:0] w_cnt;
    logic [CNT_WIDTH-1:0] w_idx;
    logic [WIDTH-1:0]     w_clear;
    logic                 w_valid;
    logic                 w_last;
    logic                 w_in_beat;
    logic                 w_out_beat;

    // Zero counter: trailing zeros when MODE=0, leading zeros when MODE=1.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_cnt = '0;
        if (MODE == 1'b0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (r_mask[i]) w_cnt = CNT_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_mask[i]) w_cnt = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
    end

    assign w_idx      = (MODE == 1'b0) ? w_cnt : CNT_WIDTH'(WIDTH - 1) - w_cnt;
    assign w_valid    = |r_mask;
    assign w_last     = w_valid && ((r_mask & (r_mask - WIDTH'(1))) == '0);
    assign w_clear    = WIDTH'(1) << w_idx;

    assign out_valid_o = w_valid;
    assign out_idx_o   = w_valid ? w_idx : '0;
    assign out_last_o  = w_last;

    // out_ready_i -> in_ready_o is combinational so a new mask can follow the last beat.
    assign in_ready_o = !flush_i && (!w_valid || (out_ready_i && w_last));
    assign w_in_beat  = in_valid_i && in_ready_o;
    assign w_out_beat = w_valid && out_ready_i;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mask <= '0;
        end else if (flush_i) begin
            r_mask <= '0;
        end else if (w_in_beat) begin
            r_mask <= in_mask_i;
        end else if (w_out_beat) begin
            r_mask <= r_mask & ~w_clear;
        end
    end

endmodule

// File: doc/set_bit_iter.md
# set_bit_iter

Sequential set-bit iterator: accepts a WIDTH-bit mask over a valid/ready handshake and returns the index of every set bit, one index per output handshake, in priority order (LSB-first or MSB-first). It is the stream-side counterpart of the leading/trailing-zero counter. That counter reduces a vector to one index combinationally; this block walks the whole vector. It sits between request-vector producers (arbiter grants, pending-interrupt masks, dirty-line bitmaps) and index-based consumers.

## Interface
- WIDTH, default 8: width of the input mask; must be >= 1.
- MODE, default 1'b0: 0 emits indices from the LSB upward; 1 emits them from the MSB downward.
- CNT_WIDTH, default cf_math_pkg::idx_width(WIDTH): dependent parameter, do not override.
- clk_i, input, 1: clock, rising edge.
- rst_ni, input, 1: asynchronous active-low reset.
- flush_i, input, 1: synchronous abort; discards the mask currently being iterated.
- in_valid_i, input, 1: in_mask_i is valid.
- in_ready_o, output, 1: block can accept a mask.
- in_mask_i, input, WIDTH: mask to iterate.
- out_valid_o, output, 1: out_idx_o is valid.
- out_ready_i, input, 1: consumer takes the current index.
- out_idx_o, output, CNT_WIDTH: bit position in in_mask_i numbering; bit 0 is the LSB in both modes.
- out_last_o, output, 1: current index is the final set bit of the mask.

## Operation
- State: a WIDTH-bit register mask_q holds the not-yet-emitted bits. The block is busy when mask_q != 0. No other state is needed.
- out_valid_o = (mask_q != 0).
- out_idx_o = index of the first set bit of mask_q: the lowest set bit when MODE=0, the highest when MODE=1. Derive it through an instance of the zero counter with the matching MODE. When MODE=1, convert the leading-zero count to a bit position: WIDTH-1-cnt.
- out_last_o = out_valid_o && exactly one bit of mask_q is set, i.e. (mask_q & (mask_q-1)) == 0.
- When out_valid_o=0, force out_idx_o and out_last_o to 0.
- Output beat: out_valid_o && out_ready_i. On a beat, clear bit out_idx_o in mask_q.
- in_ready_o = !flush_i && (!out_valid_o || (out_ready_i && out_last_o)).
  - This is a combinational path from out_ready_i to in_ready_o. It is intentional and allows back-to-back masks without a bubble.
- Input beat: in_valid_i && in_ready_o. On a beat, load in_mask_i into mask_q. The load overrides the clear caused by a simultaneous last output beat.
- An all-zero mask is accepted and produces no output beat; the block stays idle.
- flush_i=1 sets mask_q to 0 on the next edge, regardless of the handshakes. No input is accepted in a flush cycle.
- WIDTH=1: out_idx_o is constant 0 and CNT_WIDTH is 1.

## Timing
- Reset, asynchronous: mask_q=0. Resulting outputs: out_valid_o=0, out_idx_o=0, out_last_o=0, in_ready_o=1 (when flush_i=0).
- Reset asserted mid-iteration discards the mask immediately; outputs take their reset values without waiting for a clock edge.
- Latency: a mask accepted at edge N presents its first index in the cycle after edge N. There is no combinational in-to-out path.
- Throughput: a mask with k set bits (k >= 1) occupies exactly k cycles when out_ready_i is held high. Back-to-back masks stream without idle cycles.
- Stability: while out_valid_o=1 and out_ready_i=0, out_idx_o and out_last_o hold their values and out_valid_o does not drop. The only exceptions are flush and reset.
- out_valid_o never depends on out_ready_i in the same cycle.
- Simultaneous flush_i and an output beat: the beat completes in that cycle (the consumer sees it), and mask_q is 0 after the edge.

## Test plan
- Reset, then idle with in_valid_i=0: out_valid_o=0, out_idx_o=0, out_last_o=0, in_ready_o=1.
- WIDTH=8, MODE=0, mask 8'b1010_0100, out_ready_i=1:
  - indices 2, 5, 7 appear on three consecutive cycles;
  - out_last_o=1 only with index 7;
  - in_ready_o=1 only in the index-7 cycle.
- WIDTH=8, MODE=1, same mask: indices 7, 5, 2, with out_last_o on index 2.
- Backpressure on mask 8'b1010_0100: hold out_ready_i=0 for 3 cycles while index 2 is shown.
  - Index 2 stays stable with out_valid_o=1 and in_ready_o=0.
  - Releasing out_ready_i then yields 5 and 7 on consecutive cycles.
- Back-to-back masks 8'h01, 8'h00, 8'h80 with in_valid_i held high:
  - index 0 is emitted with out_last_o=1, then index 7 with out_last_o=1;
  - the 8'h00 mask is accepted and produces no beat;
  - between the two indices there is exactly one idle output cycle, the cycle that consumes 8'h00.
- Flush and reset during iteration, mask 8'hFF, WIDTH=8:
  - Pulse flush_i in the cycle index 1 is shown: that beat completes, then out_valid_o=0 and in_ready_o=1.
  - Reload 8'hFF, then assert rst_ni=0 between clock edges: out_valid_o=0 immediately.
